// File: rtl/gpr_pkg.sv
// Shared constants and the priority-resolved write-match helper for the
// multi-port register file.
package gpr_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int ZERO_ADDR  = 0;
   localparam int MAX_WR     = 16;
   localparam int PRIO_W     = $clog2(MAX_WR);

   typedef struct packed {
      logic              hit;
      logic [PRIO_W-1:0] idx;
   } wr_match_t;

   // Highest set bit wins, so the highest-index write port takes priority.
   function automatic wr_match_t wr_match(input logic [MAX_WR-1:0] hits);
      wr_match_t m;
      m.hit = |hits;
      m.idx = '0;
      for (int i = 0; i < MAX_WR; i++) begin
         if (hits[i]) m.idx = PRIO_W'(i);
      end
      return m;
   endfunction

endpackage

// File: rtl/gpr_file_mp_if.sv
// Decode/writeback-facing bus of the register file: read ports, write ports,
// issue marking and scoreboard status.
interface gpr_file_mp_if
   import gpr_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_ready;
   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     flush;
   logic                     any_pending;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
      input  rd_data, rd_ready, any_pending
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
      output rd_data, rd_ready, any_pending
   );
endinterface

// File: rtl/gpr_scoreboard.sv
// Per-register pending bits: issue sets, write or flush clears, with a new
// issue superseding a clear to the same register in the same cycle.
module gpr_scoreboard
   import gpr_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_WR-1:0]        i_wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
   input  logic                     i_iss_en,
   input  logic [ADDR_W-1:0]        i_iss_addr,
   input  logic                     i_flush,
   output logic [2**ADDR_W-1:0]     o_pend,
   output logic                     o_any_pending
);
   localparam int DEPTH = 2**ADDR_W;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_pend
         logic w_set;
         logic w_clr;
         logic r_pend;

         always_comb begin
            w_set = i_iss_en && (i_iss_addr == ADDR_W'(gi))
                    && !((ZERO_REG != 0) && (gi == ZERO_ADDR));
            w_clr = i_flush;
            for (int w = 0; w < NUM_WR; w++) begin
               if (i_wr_en[w] && (i_wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(gi)))
                  w_clr = 1'b1;
            end
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset)     r_pend <= 1'b0;
            else if (w_set) r_pend <= 1'b1;
            else if (w_clr) r_pend <= 1'b0;
         end

         assign o_pend[gi] = r_pend;
      end
   endgenerate

   assign o_any_pending = |o_pend;
endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port general-purpose register file with prioritised writes, optional
// write-through bypass and a pending scoreboard for decode stalls.
module gpr_file_mp
   import gpr_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic          clk,
   input  logic          reset,
   gpr_file_mp_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] w_regs [DEPTH];
   logic [DEPTH-1:0]  w_pend;

   // Enabled write ports targeting address a; register 0 never matches when hardwired.
   function automatic logic [MAX_WR-1:0] hits_for(
      input logic [NUM_WR-1:0]        en,
      input logic [NUM_WR*ADDR_W-1:0] addrs,
      input logic [ADDR_W-1:0]        a
   );
      logic [MAX_WR-1:0] h;
      h = '0;
      for (int w = 0; w < NUM_WR; w++) begin
         h[w] = en[w] && (addrs[w*ADDR_W +: ADDR_W] == a)
                && !((ZERO_REG != 0) && (a == ADDR_W'(ZERO_ADDR)));
      end
      return h;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_reg
         wr_match_t         w_m;
         logic [DATA_W-1:0] r_word;

         always_comb w_m = wr_match(hits_for(bus.wr_en, bus.wr_addr, ADDR_W'(gi)));

         always_ff @(posedge clk or negedge reset) begin
            if (!reset)     r_word <= '0;
            else if (w_m.hit) r_word <= bus.wr_data[w_m.idx*DATA_W +: DATA_W];
         end

         assign w_regs[gi] = r_word;
      end

      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] w_a;
         logic              w_zero;
         logic              w_byp;
         wr_match_t         w_m;

         assign w_a    = bus.rd_addr[gi*ADDR_W +: ADDR_W];
         assign w_zero = (ZERO_REG != 0) && (w_a == ADDR_W'(ZERO_ADDR));
         always_comb w_m = wr_match(hits_for(bus.wr_en, bus.wr_addr, w_a));
         assign w_byp  = (BYPASS != 0) && w_m.hit;

         assign bus.rd_data[gi*DATA_W +: DATA_W] =
            w_zero ? '0 :
            w_byp  ? bus.wr_data[w_m.idx*DATA_W +: DATA_W] :
                     w_regs[w_a];
         assign bus.rd_ready[gi] = w_zero || !w_pend[w_a] || w_byp;
      end
   endgenerate

   gpr_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk           (clk),
      .reset         (reset),
      .i_wr_en       (bus.wr_en),
      .i_wr_addr     (bus.wr_addr),
      .i_iss_en      (bus.iss_en),
      .i_iss_addr    (bus.iss_addr),
      .i_flush       (bus.flush),
      .o_pend        (w_pend),
      .o_any_pending (bus.any_pending)
   );
endmodule

// File: doc/gpr_file_mp.md
Name: gpr_file_mp

Overview:
- Parametrised multi-port general-purpose register file; successor to the single-write, two-read GRF in the decode stage.
- Adds the following over the current GRF:
  - configurable width, depth, read-port count and write-port count;
  - deterministic write-port priority;
  - optional write-through bypass;
  - per-register pending scoreboard, which decode uses for stall generation.
- Sits between decode (read, issue) and writeback (write).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports; higher index has higher priority
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_ready  out  NUM_RD  1 = value on rd_data is architecturally final (not pending)
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- iss_en  in  1  mark iss_addr as pending (producer issued)
- iss_addr  in  ADDR_W  destination of issued producer
- flush  in  1  synchronous clear of all pending bits
- any_pending  out  1  OR of all pending bits

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers cleared to 0;
  - all pending bits cleared to 0;
  - outputs then read 0, rd_ready all 1, any_pending 0.
  - Effective immediately, independent of clk.
  - A write or issue in the same cycle that reset deasserts is ignored only if reset is still low at the edge.
- Write, at posedge:
  - for each port w with wr_en[w]=1 and, when ZERO_REG=1, wr_addr[w]!=0: reg[wr_addr[w]] <= wr_data[w].
  - Several ports writing the same address: highest-index enabled port wins.
- Read: combinational, zero latency.
  - BYPASS=1: rd_data[k] = data of the highest-index enabled write port whose address matches rd_addr[k] (excluding addr 0 when ZERO_REG=1); otherwise reg[rd_addr[k]].
  - BYPASS=0: always reg[rd_addr[k]].
  - ZERO_REG=1 and rd_addr[k]=0: rd_data[k]=0 regardless of writes.
- Pending scoreboard: one bit per register, updated at posedge.
  - Clear: any enabled write to address a clears pend[a].
  - Set: iss_en=1 sets pend[iss_addr].
  - Same address set and cleared in one cycle: set wins, because the new producer supersedes the old.
  - iss_addr=0 with ZERO_REG=1: ignored.
  - flush=1: clears every pending bit, but an iss_en in the same cycle still sets its bit.
  - Register contents are unaffected by flush.
- rd_ready[k]:
  - !pend[rd_addr[k]], OR (BYPASS=1 AND an enabled write to rd_addr[k] occurs this cycle);
  - always 1 for address 0 when ZERO_REG=1.
- Counters/wrap: none; addresses are always in range (depth = 2**ADDR_W).
- No X propagation: unwritten registers read 0 after reset.

Decomposition:
- Shared package gpr_pkg:
  - default DATA_W/ADDR_W constants;
  - ZERO_ADDR constant;
  - function for priority-resolved write match, reused by the bypass and write logic.
- One natural sub-module, gpr_scoreboard:
  - contains the pending bit vector, set/clear/flush priority logic, and the any_pending reduction;
  - the register array and bypass muxing stay in gpr_file_mp.

Test Plan:
- Reset mid-run:
  - stimulus: write reg 5=0xDEADBEEF and issue reg 7, then pull reset low between edges;
  - response: rd_data for addr 5 reads 0 immediately, rd_ready=1, any_pending=0.
- Dual-write conflict:
  - stimulus: wr_en=2'b11, both addr 3, data 0x11111111 (port0) and 0x22222222 (port1);
  - response: bypass read of 3 gives 0x22222222 the same cycle; stored value is 0x22222222 next cycle.
- Zero register:
  - stimulus: write 0xFFFFFFFF to addr 0 on both ports, and issue addr 0;
  - response: rd_data=0, rd_ready=1, any_pending=0.
- Scoreboard:
  - stimulus: issue addr 9 at cycle 1;
  - response: rd_ready=0 at cycle 2;
  - stimulus: write 9=0xA5A5A5A5 at cycle 4;
  - response: rd_ready=1 with bypassed data at cycle 4, stored value from cycle 5.
- Set/clear same cycle:
  - stimulus: pend[4]=1, then write 4 and issue 4 in the same cycle;
  - response: pend[4] remains 1 and rd_ready=0 next cycle.
- Flush:
  - stimulus: pending on 2, 6, 10, then flush=1 with iss_en on 12;
  - response: only pend[12]=1, any_pending=1, register contents unchanged.
- BYPASS=0 build:
  - stimulus: same-cycle write 8=0x12345678 and read 8;
  - response: old value 0 that cycle, 0x12345678 next cycle.
